// File: rtl/add_pipe_pkg.sv
// Shared definitions for add_pipe: op encoding and saturation clamp constants.
// Clamp constants are produced at CLAMP_W bits and sliced to WIDTH by the user (WIDTH <= CLAMP_W).
package add_pipe_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  localparam int CLAMP_W = 64;

  // want_max selects the upper clamp, otherwise the lower clamp.
  function automatic logic [CLAMP_W-1:0] clamp_const(input int width, input bit is_signed,
                                                     input bit want_max);
    logic [CLAMP_W-1:0] ones;
    logic [CLAMP_W-1:0] c;
    ones = {CLAMP_W{1'b1}} >> (CLAMP_W - width);
    if (is_signed) begin
      c = want_max ? (ones >> 1) : (~(ones >> 1) & ones);
    end else begin
      c = want_max ? ones : '0;
    end
    return c;
  endfunction

endpackage

// File: rtl/add_pipe_stage.sv
// One handshake register stage holding {valid, sum, ovf}; loads when empty or when downstream loads.
// Latency 1 cycle; stalls by holding its contents while full and downstream does not load.
module add_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_sum,
  input  logic             up_ovf,
  input  logic             dn_load,
  output logic             load,
  output logic             v,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  assign load = !v || dn_load;

  // On a bubble only the valid bit drops; the data is left as it was.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v   <= 1'b0;
      sum <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      v <= up_valid;
      if (up_valid) begin
        sum <= up_sum;
        ovf <= up_ovf;
      end
    end
  end

endmodule

// File: rtl/add_pipe.sv
// Pipelined add/sub with overflow flag; latency STAGES, full throughput, bubbles collapse under backpressure.
// Optional ADD_PIPE_SAT_EN makes overflowing results saturate instead of wrapping.
module add_pipe
  import add_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int SIGNED = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf
);

`ifdef ADD_PIPE_SAT_EN
  localparam logic [CLAMP_W-1:0] SAT_MAX_W = clamp_const(WIDTH, SIGNED != 0, 1'b1);
  localparam logic [CLAMP_W-1:0] SAT_MIN_W = clamp_const(WIDTH, SIGNED != 0, 1'b0);
  localparam logic [WIDTH-1:0]   SAT_MAX   = SAT_MAX_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0]   SAT_MIN   = SAT_MIN_W[WIDTH-1:0];
`endif

  op_t              op;
  logic [WIDTH:0]   a_x;
  logic [WIDTH:0]   b_x;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] res;
  logic             ovf;

  assign op = op_t'(in_op);

  always_comb begin
    a_x  = {1'b0, in_a};
    b_x  = {1'b0, in_b};
    wide = (op == OP_SUB) ? (a_x - b_x) : (a_x + b_x);
    // Unsigned: bit WIDTH is the carry (add) or borrow (sub).
    if (SIGNED != 0) begin
      ovf = ((op == OP_SUB) ? (in_a[WIDTH-1] != in_b[WIDTH-1])
                            : (in_a[WIDTH-1] == in_b[WIDTH-1]))
            && (wide[WIDTH-1] != in_a[WIDTH-1]);
    end else begin
      ovf = wide[WIDTH];
    end
    res = wide[WIDTH-1:0];
`ifdef ADD_PIPE_SAT_EN
    // Signed overflow direction follows the sign of a.
    if (ovf) begin
      if (SIGNED != 0) res = in_a[WIDTH-1] ? SAT_MIN : SAT_MAX;
      else             res = (op == OP_SUB) ? SAT_MIN : SAT_MAX;
    end
`endif
  end

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] ovf_q;
  logic [WIDTH-1:0]  sum_q [STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic ld;
    logic dn;
    logic             up_v;
    logic [WIDTH-1:0] up_s;
    logic             up_o;

    if (i == STAGES - 1) begin : g_last
      assign dn = out_ready;
    end else begin : g_mid
      assign dn = g_stage[i+1].ld;
    end

    if (i == 0) begin : g_first
      assign up_v = in_valid;
      assign up_s = res;
      assign up_o = ovf;
    end else begin : g_next
      assign up_v = v[i-1];
      assign up_s = sum_q[i-1];
      assign up_o = ovf_q[i-1];
    end

    add_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clock   (clock),
      .reset_n (reset_n),
      .up_valid(up_v),
      .up_sum  (up_s),
      .up_ovf  (up_o),
      .dn_load (dn),
      .load    (ld),
      .v       (v[i]),
      .sum     (sum_q[i]),
      .ovf     (ovf_q[i])
    );
  end

  assign in_ready  = g_stage[0].ld;
  assign out_valid = v[STAGES-1];
  assign out_sum   = sum_q[STAGES-1];
  assign out_ovf   = ovf_q[STAGES-1];

endmodule
